div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Initiator side of the iterative divider handshake. Decodes RV32M DIV/DIVU/REM/REMU from EX,
//  stalls the pipeline, launches the divider and captures quotient/remainder. Resolves div-by-zero
//  and signed overflow locally, then presents one writeback beat to the WB mux.
// PARAMETERS
//  DW          32  operand/result width
//  DIV_TIMEOUT 40  max cycles in WAIT before abort (must exceed divider latency, DW+3)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset; one clock; reset is asynchronous and active-low
//  ex_req_i       in   1   EX holds a valid M-ext divide op
//  ex_funct3_i    in   3   100 DIV, 101 DIVU, 110 REM, 111 REMU
//  ex_rs1_i       in   DW  dividend
//  ex_rs2_i       in   DW  divisor
//  ex_rd_i        in   5   destination register
//  flush_i        in   1   pipeline flush (branch/trap)
//  div_dividend_o out  DW  to divider
//  div_divisor_o  out  DW  to divider
//  div_signed_o   out  1   signed op
//  div_en_o       out  1   start pulse
//  div_busy_i     in   1   divider computing
//  div_done_i     in   1   divider result valid
//  div_quot_i     in   DW  quotient
//  div_rem_i      in   DW  remainder
//  stall_o        out  1   hold IF/ID/EX
//  wb_en_o        out  1   writeback strobe, one cycle
//  wb_rd_o        out  5   writeback register
//  wb_data_o      out  DW  writeback data
//  err_o          out  1   sticky timeout flag, cleared by reset only
// BEHAVIOUR
//  Reset: state IDLE; every output 0; operand/rd/op registers 0.
//  FSM IDLE->ISSUE->WAIT->DONE->IDLE; IDLE->DONE (special case); WAIT->DRAIN->IDLE (flush).
//  IDLE: ex_req_i & !flush_i latches rs1/rs2/rd/funct3 that cycle. Div-by-zero or signed
//   overflow -> DONE; otherwise -> ISSUE.
//  ISSUE: div_en_o=1 for exactly this cycle; operands stay driven until DONE -> WAIT.
//  WAIT: cycle counter from 0. div_done_i=1 -> capture quot/rem, -> DONE.
//   Counter == DIV_TIMEOUT -> err_o=1, result 0, -> DONE.
//  DONE: wb_en_o=1; wb_data_o = quot (funct3[1]=0) or rem (funct3[1]=1) -> IDLE.
//  stall_o = (IDLE & ex_req_i & !flush_i) | ISSUE | WAIT. Low in DONE, so EX advances in the WB cycle.
//  Latency, req cycle 0: special -> wb_en_o cycle 1; normal -> wb_en_o 1 cycle after div_done_i.
//  Special results, no divider start:
//   divisor 0: quot all-ones, rem = rs1.
//   signed rs1=2^(DW-1), rs2=-1: quot = rs1, rem 0.
//  flush_i: IDLE/ISSUE -> IDLE, no writeback. WAIT -> DRAIN.
//   DRAIN holds until div_done_i or !div_busy_i, discards result -> IDLE. stall_o=0 in DRAIN;
//   requests in DRAIN are not accepted.
//  flush_i in DONE: wb_en_o forced 0.
//  div_done_i outside WAIT/DRAIN: ignored.
// CONFIGURATION
//  DIV_RESULT_CACHE_EN defined: keep last {rs1,rs2,signed,quot,rem} (valid bit cleared by reset,
//   flush and timeout). An IDLE request with an identical operand tuple -> DONE in 1 cycle,
//   no div_en_o. A DIV/REM pair costs one divide.
//  Undefined: no cache; every non-special op runs the divider.
// STRUCTURE
//  Package div_pkg: funct3 constants F3_DIV/F3_DIVU/F3_REM/F3_REMU, state enum
//   (IDLE, ISSUE, WAIT, DONE, DRAIN), DW default.
//  Sub-module div_special_chk: combinational zero/overflow detect and fixed-result generation.
// TESTING
//  DIVU 100/7, rd=5 -> one div_en_o pulse; wb_en_o after done; rd=5, data 14.
//  REM -7/2 -> data 0xFFFFFFFF. DIV -7/2 -> data 0xFFFFFFFD (model returns truncated values).
//  DIV 5/0 -> no div_en_o; wb_en_o cycle 1, data 0xFFFFFFFF. REMU 5/0 -> data 5.
//  DIV 0x80000000/0xFFFFFFFF -> data 0x80000000, 1 cycle. REM same operands -> data 0.
//  flush_i 3 cycles into WAIT -> stall_o drops, no wb_en_o; next req waits for done, then issues.
//  Model never asserts done -> err_o=1 at DIV_TIMEOUT, wb_en_o data 0, stall_o released.
//  CACHE_EN: DIV 9/4 then REM 9/4 -> one div_en_o total; second wb_en_o 1 cycle, data 1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divide issue controller: funct3 encodings, FSM states, default width.
// Pure declarations, no logic and no state.
// Backpressure: not applicable.
package div_pkg;

    localparam int DW_DEFAULT = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        DRAIN
    } state_e;

    function automatic logic is_div_op(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/div_special_chk.sv
// Detects divide-by-zero and signed overflow and produces their fixed quotient/remainder.
// Latency: combinational.
// Backpressure: none, pure function of the operands.
module div_special_chk
    import div_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] rs1,
    input  logic [DW-1:0] rs2,
    input  logic          is_signed,
    output logic          hit,
    output logic [DW-1:0] quot,
    output logic [DW-1:0] rem
);

    logic div_zero;
    logic ovf;

    assign div_zero = (rs2 == '0);
    assign ovf      = is_signed && (rs1 == {1'b1, {(DW-1){1'b0}}}) && (rs2 == '1);
    assign hit      = div_zero || ovf;

    // Overflow returns the dividend as quotient, which is also what ovf's rs1 already holds.
    assign quot = div_zero ? '1 : rs1;
    assign rem  = div_zero ? rs1 : '0;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues RV32M DIV/DIVU/REM/REMU to the iterative divider and writes back one result; DIV_RESULT_CACHE_EN adds a last-result cache.
// Latency: special case (or cache hit) gives wb_en_o 1 cycle after acceptance; otherwise 1 cycle after div_done_i.
// Backpressure: stall_o holds EX from acceptance until the writeback cycle; a flush aborts and drains the divider.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_req_i,
    input  logic [2:0]    ex_funct3_i,
    input  logic [DW-1:0] ex_rs1_i,
    input  logic [DW-1:0] ex_rs2_i,
    input  logic [4:0]    ex_rd_i,
    input  logic          flush_i,
    output logic [DW-1:0] div_dividend_o,
    output logic [DW-1:0] div_divisor_o,
    output logic          div_signed_o,
    output logic          div_en_o,
    input  logic          div_busy_i,
    input  logic          div_done_i,
    input  logic [DW-1:0] div_quot_i,
    input  logic [DW-1:0] div_rem_i,
    output logic          stall_o,
    output logic          wb_en_o,
    output logic [4:0]    wb_rd_o,
    output logic [DW-1:0] wb_data_o,
    output logic          err_o
);

    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [DW-1:0] rs1_q, rs2_q, quot_q, rem_q;
    logic [4:0]    rd_q;
    logic [1:0]    op_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          accept, spec_hit, cache_hit, capture, timeout, in_div;
    logic [DW-1:0] spec_quot, spec_rem, cache_quot, cache_rem;

    assign accept = (state_q == IDLE) && ex_req_i && is_div_op(ex_funct3_i) && !flush_i;
    assign in_div = (state_q == ISSUE) || (state_q == WAIT);

    div_special_chk #(.DW(DW)) u_special_chk (
        .rs1       (ex_rs1_i),
        .rs2       (ex_rs2_i),
        .is_signed (!ex_funct3_i[0]),
        .hit       (spec_hit),
        .quot      (spec_quot),
        .rem       (spec_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_en_o = 1'b0;
        wb_en_o  = 1'b0;
        stall_o  = 1'b0;
        capture  = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    state_d = (spec_hit || cache_hit) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                stall_o = 1'b1;
                // A flushed op never starts the divider, so there is nothing to drain.
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    div_en_o = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = div_done_i ? IDLE : DRAIN;
                end else if (div_done_i) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CW'(DIV_TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                wb_en_o = !flush_i;
                state_d = IDLE;
            end
            DRAIN: begin
                if (div_done_i || !div_busy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            op_q   <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                rs1_q <= ex_rs1_i;
                rs2_q <= ex_rs2_i;
                rd_q  <= ex_rd_i;
                op_q  <= ex_funct3_i[1:0];
                // Special results win over the cache; a cached tuple can never be special.
                quot_q <= spec_hit ? spec_quot : cache_quot;
                rem_q  <= spec_hit ? spec_rem  : cache_rem;
            end else if (capture) begin
                quot_q <= div_quot_i;
                rem_q  <= div_rem_i;
            end else if (timeout) begin
                quot_q <= '0;
                rem_q  <= '0;
            end
            cnt_q <= (state_q == WAIT) ? cnt_q + CW'(1) : '0;
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef DIV_RESULT_CACHE_EN
    logic          c_vld, c_sgn;
    logic [DW-1:0] c_rs1, c_rs2;

    assign cache_hit = c_vld && (c_rs1 == ex_rs1_i) && (c_rs2 == ex_rs2_i)
                     && (c_sgn == !ex_funct3_i[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld      <= 1'b0;
            c_sgn      <= 1'b0;
            c_rs1      <= '0;
            c_rs2      <= '0;
            cache_quot <= '0;
            cache_rem  <= '0;
        end else if (flush_i || timeout) begin
            c_vld <= 1'b0;
        end else if (capture) begin
            c_vld      <= 1'b1;
            c_sgn      <= !op_q[0];
            c_rs1      <= rs1_q;
            c_rs2      <= rs2_q;
            cache_quot <= div_quot_i;
            cache_rem  <= div_rem_i;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_quot = '0;
    assign cache_rem  = '0;
`endif

    assign div_dividend_o = in_div ? rs1_q : '0;
    assign div_divisor_o  = in_div ? rs2_q : '0;
    assign div_signed_o   = in_div && !op_q[0];
    assign wb_rd_o        = wb_en_o ? rd_q : '0;
    assign wb_data_o      = wb_en_o ? (op_q[1] ? rem_q : quot_q) : '0;
    assign err_o          = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider, reference model with scoreboard, directed and random ops.
module tb_div_issue_ctrl;
    import div_pkg::*;

    localparam int W  = 32;
    localparam int TO = 40;
`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ex_req_i, flush_i;
    logic [2:0]    ex_funct3_i;
    logic [W-1:0]  ex_rs1_i, ex_rs2_i;
    logic [4:0]    ex_rd_i;
    logic [W-1:0]  div_dividend_o, div_divisor_o;
    logic          div_signed_o, div_en_o;
    logic          div_busy_i, div_done_i;
    logic [W-1:0]  div_quot_i, div_rem_i;
    logic          stall_o, wb_en_o, err_o;
    logic [4:0]    wb_rd_o;
    logic [W-1:0]  wb_data_o;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DW(W), .DIV_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_req_i(ex_req_i), .ex_funct3_i(ex_funct3_i), .ex_rs1_i(ex_rs1_i),
        .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
        .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_signed_o(div_signed_o), .div_en_o(div_en_o),
        .div_busy_i(div_busy_i), .div_done_i(div_done_i),
        .div_quot_i(div_quot_i), .div_rem_i(div_rem_i),
        .stall_o(stall_o), .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .err_o(err_o)
    );

    typedef struct {
        logic [4:0]   rd;
        logic [W-1:0] data;
        int           kind;   // 0 short path, 1 via divider, 2 timeout
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           en_cnt = 0;
    logic         prev_done = 1'b0;
    logic         err_exp = 1'b0;
    bit           hang = 1'b0;
    int           lat_next = 4;
    // reference-model cache of the last divider-computed tuple
    bit           c_vld = 1'b0;
    bit           c_s;
    logic [W-1:0] c_a, c_b;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Behavioural iterative divider with a programmable latency.
    int           m_cnt;
    logic [W-1:0] m_a, m_b, m_q, m_r;
    logic         m_s;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy_i <= 1'b0;
            div_done_i <= 1'b0;
            div_quot_i <= '0;
            div_rem_i  <= '0;
            m_cnt      <= 0;
        end else begin
            div_done_i <= 1'b0;
            if (div_en_o) begin
                div_busy_i <= 1'b1;
                m_a        <= div_dividend_o;
                m_b        <= div_divisor_o;
                m_s        <= div_signed_o;
                m_cnt      <= lat_next;
            end else if (div_busy_i && !hang) begin
                if (m_cnt == 0) begin
                    ref_div(m_s, m_a, m_b, m_q, m_r);
                    div_busy_i <= 1'b0;
                    div_done_i <= 1'b1;
                    div_quot_i <= m_q;
                    div_rem_i  <= m_r;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every writeback beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (div_en_o) en_cnt++;
            if (wb_en_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wb", {27'd0, wb_rd_o}, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.kind == 2) err_exp = 1'b1;
                    chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
                    chk("wb_data", wb_data_o, e.data);
                    chk("err_flag", {31'd0, err_o}, {31'd0, err_exp});
                    if (e.kind == 1) chk("wb_after_done", {31'd0, prev_done}, 32'd1);
                end
            end
            prev_done = div_done_i;
        end
    end

    task automatic send(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd);
        logic [W-1:0] q, r;
        exp_t         e;
        bit           sgn, short_exp;
        int           hold, en0;
        sgn = !f3[0];
        ref_div(sgn, a, b, q, r);
        short_exp = (b == '0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                  || (CACHE && c_vld && c_a == a && c_b == b && c_s == sgn);
        e.rd   = rd;
        e.data = f3[1] ? r : q;
        if (short_exp) begin
            e.kind = 0;
        end else if (hang) begin
            e.kind = 2;
            e.data = '0;
            c_vld  = 1'b0;
        end else begin
            e.kind = 1;
            c_vld  = 1'b1;
            c_a    = a;
            c_b    = b;
            c_s    = sgn;
        end
        sb.push_back(e);
        en0 = en_cnt;
        ex_req_i    = 1'b1;
        ex_funct3_i = f3;
        ex_rs1_i    = a;
        ex_rs2_i    = b;
        ex_rd_i     = rd;
        hold = 0;
        while (1) begin
            #1;
            if (!stall_o) break;
            hold++;
            if (hold > 200) begin
                chk("stall_timeout", 32'(hold), 32'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        ex_req_i = 1'b0;
        if (short_exp) begin
            chk("short_latency", 32'(hold), 32'd1);
            chk("short_no_en", 32'(en_cnt - en0), 32'd0);
        end else begin
            chk("long_latency", {31'd0, hold >= 3}, 32'd1);
            chk("one_en_pulse", 32'(en_cnt - en0), 32'd1);
        end
    endtask

    function automatic logic [W-1:0] rnd_a();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 200));
            1:       return 32'($urandom);
            2:       return 32'h8000_0000;
            default: return 32'(0 - $urandom_range(1, 200));
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_b();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(1, 20));
            3:       return 32'(0 - $urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0;
        ex_req_i = 1'b0; flush_i = 1'b0; ex_funct3_i = '0;
        ex_rs1_i = '0; ex_rs2_i = '0; ex_rd_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en_o}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd_o}, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_div_en", {31'd0, div_en_o}, 32'd0);
        chk("rst_dividend", div_dividend_o, 32'd0);
        chk("rst_divisor", div_divisor_o, 32'd0);
        chk("rst_signed", {31'd0, div_signed_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(F3_DIVU, 32'd100, 32'd7, 5'd5);
        send(F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd6);
        send(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7);
        send(F3_DIV, 32'd5, 32'd0, 5'd8);
        send(F3_REMU, 32'd5, 32'd0, 5'd9);
        send(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        send(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        send(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

        // Flush three cycles into WAIT, then drain while the divider is still busy.
        lat_next = 20;
        en0 = en_cnt;
        ex_req_i = 1'b1; ex_funct3_i = F3_DIVU;
        ex_rs1_i = 32'd50; ex_rs2_i = 32'd3; ex_rd_i = 5'd13;
        repeat (5) @(negedge clk);
        flush_i = 1'b1; ex_req_i = 1'b0; c_vld = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("drain_stall", {31'd0, stall_o}, 32'd0);
        chk("flush_one_en", 32'(en_cnt - en0), 32'd1);
        ex_req_i = 1'b1; ex_funct3_i = F3_DIV; ex_rs1_i = 32'd1; ex_rs2_i = 32'd1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("drain_no_accept_stall", {31'd0, stall_o}, 32'd0);
        end
        ex_req_i = 1'b0;
        chk("drain_no_en", 32'(en_cnt - en0), 32'd1);
        for (int i = 0; i < 100 && div_busy_i; i++) @(negedge clk);
        chk("drain_divider_idle", {31'd0, div_busy_i}, 32'd0);
        repeat (2) @(negedge clk);
        lat_next = 3;
        send(F3_DIV, 32'd1000, 32'hFFFF_FFF6, 5'd14);

        // DIV then REM of the same operands: one divide when the cache is built in.
        send(F3_DIV, 32'd9, 32'd4, 5'd15);
        send(F3_REM, 32'd9, 32'd4, 5'd16);

        for (int i = 0; i < 40; i++) begin
            lat_next = $urandom_range(0, 30);
            send({1'b1, 2'($urandom_range(0, 3))}, rnd_a(), rnd_b(), 5'($urandom_range(0, 31)));
        end

        chk("err_before_timeout", {31'd0, err_o}, 32'd0);
        hang = 1'b1;
        send(F3_DIVU, 32'd77, 32'd3, 5'd17);
        hang = 1'b0;
        lat_next = 2;
        send(F3_REMU, 32'd77, 32'd3, 5'd18);
        send(F3_DIV, 32'd9, 32'd4, 5'd19);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("err_sticky", {31'd0, err_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
